// File: rtl/counter_share_arbiter_pkg.sv
// Shared types and helpers for the counter-share arbiter.
// Optional feature macro: CSA_FIXED_PRIO_EN (fixed-priority selection).
package counter_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned CW_DEF   = 8;

  // Wide enough for the largest supported NREQ; callers truncate to NREQ bits.
  function automatic logic [7:0] onehot(input int unsigned idx);
    return 8'(1) << idx;
  endfunction

endpackage

// File: rtl/counter_share_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// Optional feature macro: CSA_FIXED_PRIO_EN (no effect on this interface).
interface counter_share_arbiter_if
  import counter_share_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned CW   = CW_DEF
);

  logic                 clr;
  logic [NREQ-1:0]      req;
  logic [NREQ*CW-1:0]   len;
  logic [NREQ-1:0]      gnt;
  logic                 busy;
  logic [CW-1:0]        cnt;
  logic [NREQ-1:0]      done;

  modport master (
    output clr, req, len,
    input  gnt, busy, cnt, done
  );

  modport slave (
    input  clr, req, len,
    output gnt, busy, cnt, done
  );

endinterface

// File: rtl/counter_share_arbiter_rr_picker.sv
// Combinational winner selection: round-robin after 'last', or a plain
// priority encoder when CSA_FIXED_PRIO_EN is defined.
module rr_picker #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
`ifndef CSA_FIXED_PRIO_EN
  input  logic [IW-1:0]   last,
`endif
  output logic [IW-1:0]   winner,
  output logic            valid
);

  always_comb begin
    winner = '0;
    valid  = |req;
`ifdef CSA_FIXED_PRIO_EN
    for (int unsigned i = NREQ; i > 0; i--) begin
      if (req[i-1]) winner = IW'(i - 1);
    end
`else
    // Walk the search order backwards so the closest hit after 'last' wins.
    for (int unsigned k = NREQ; k > 0; k--) begin
      logic [IW-1:0] w_cand;
      w_cand = IW'((32'(last) + k) % NREQ);
      if (req[w_cand]) winner = w_cand;
    end
`endif
  end

endmodule

// File: rtl/counter_share_arbiter.sv
// Shares one up-counter among NREQ requesters, one timed slot at a time.
// Optional feature macro: CSA_FIXED_PRIO_EN (fixed priority, no rr pointer).
module counter_share_arbiter
  import counter_share_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned CW   = CW_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  counter_share_arbiter_if.slave   bus
);

  localparam int unsigned IW = $clog2(NREQ);

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [CW-1:0]   r_len_q;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic            r_busy;

  logic [IW-1:0]   w_winner;
  logic            w_valid;
  logic            w_term;

`ifdef CSA_FIXED_PRIO_EN
  rr_picker #(.NREQ(NREQ)) u_picker (
    .req    (bus.req),
    .winner (w_winner),
    .valid  (w_valid)
  );
`else
  logic [IW-1:0]   r_last;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req    (bus.req),
    .last   (r_last),
    .winner (w_winner),
    .valid  (w_valid)
  );
`endif

  // A zero length is served as a one-cycle slot.
  assign w_term = (r_len_q == '0) || (r_cnt == r_len_q - CW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_len_q <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
`ifndef CSA_FIXED_PRIO_EN
      r_last  <= IW'(NREQ - 1);
`endif
    end else if (bus.clr) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt  <= '0;
          r_done <= '0;
          r_busy <= 1'b0;
          if (w_valid) begin
            r_idx   <= w_winner;
            r_len_q <= bus.len[32'(w_winner)*CW +: CW];
            r_gnt   <= NREQ'(onehot(32'(w_winner)));
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_term) begin
            r_state <= DONE;
            r_gnt   <= '0;
            r_done  <= NREQ'(onehot(32'(r_idx)));
`ifndef CSA_FIXED_PRIO_EN
            r_last  <= r_idx;
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_done  <= '0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_done  <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt  = r_gnt;
  assign bus.cnt  = r_cnt;
  assign bus.done = r_done;
  assign bus.busy = r_busy;

endmodule

// File: tb/tb_counter_share_arbiter.sv
// Directed-vector bench for counter_share_arbiter (NREQ=4, CW=8).
// Optional feature macro: CSA_FIXED_PRIO_EN selects fixed-priority expectations.
module tb_counter_share_arbiter;

  logic clk;
  logic reset;

  counter_share_arbiter_if #(.NREQ(4), .CW(8)) bus ();

  counter_share_arbiter #(.NREQ(4), .CW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic [3:0]  req;
    logic [31:0] len;
    logic [3:0]  gnt;
    logic [7:0]  cnt;
    logic        busy;
    logic [3:0]  done;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  function automatic logic [31:0] L(input logic [7:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic add(input logic c, input logic [3:0] r, input logic [31:0] l,
                     input logic [3:0] g, input logic [7:0] n, input logic b,
                     input logic [3:0] d);
    vec_t v;
    v.clr = c; v.req = r; v.len = l; v.gnt = g; v.cnt = n; v.busy = b; v.done = d;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] last_cnt;
    logic [3:0] done_seen;
    int         n;
    logic       found;

    reset   = 1'b0;
    bus.clr = 1'b0;
    bus.req = '0;
    bus.len = '0;
    #1;
    chk("rst_gnt",  32'(bus.gnt),  0);
    chk("rst_cnt",  32'(bus.cnt),  0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;

    // single slot, requester 2, len 5
    add(0, 4'b0100, L(0,0,5,0), 4'b0100, 0, 1, 4'b0000);
    add(0, 4'b0000, L(0,0,5,0), 4'b0100, 1, 1, 4'b0000);
    add(0, 4'b0000, L(0,0,5,0), 4'b0100, 2, 1, 4'b0000);
    add(0, 4'b0000, L(0,0,5,0), 4'b0100, 3, 1, 4'b0000);
    add(0, 4'b0000, L(0,0,5,0), 4'b0100, 4, 1, 4'b0000);
    add(0, 4'b0000, L(0,0,5,0), 4'b0000, 4, 1, 4'b0100);
    add(0, 4'b0000, L(0,0,5,0), 4'b0000, 0, 0, 4'b0000);
    // len 0 on requester 3
    add(0, 4'b1000, L(0,0,0,0), 4'b1000, 0, 1, 4'b0000);
    add(0, 4'b0000, L(0,0,0,0), 4'b0000, 0, 1, 4'b1000);
    add(0, 4'b0000, L(0,0,0,0), 4'b0000, 0, 0, 4'b0000);
`ifdef CSA_FIXED_PRIO_EN
    // req 1010 held, len 2: requester 1 wins every slot
    for (int s = 0; s < 3; s++) begin
      add(0, 4'b1010, L(2,2,2,2), 4'b0010, 0, 1, 4'b0000);
      add(0, 4'b1010, L(2,2,2,2), 4'b0010, 1, 1, 4'b0000);
      add(0, 4'b1010, L(2,2,2,2), 4'b0000, 1, 1, 4'b0010);
      add(0, 4'b1010, L(2,2,2,2), 4'b0000, 0, 0, 4'b0000);
    end
    add(0, 4'b0000, L(2,2,2,2), 4'b0000, 0, 0, 4'b0000);
`else
    // all four requesting, len 1: order 0,1,2,3,0 (pointer last=3 from len-0 slot)
    add(0, 4'b1111, L(1,1,1,1), 4'b0001, 0, 1, 4'b0000);
    add(0, 4'b1111, L(1,1,1,1), 4'b0000, 0, 1, 4'b0001);
    add(0, 4'b1111, L(1,1,1,1), 4'b0000, 0, 0, 4'b0000);
    add(0, 4'b1111, L(1,1,1,1), 4'b0010, 0, 1, 4'b0000);
    add(0, 4'b1111, L(1,1,1,1), 4'b0000, 0, 1, 4'b0010);
    add(0, 4'b1111, L(1,1,1,1), 4'b0000, 0, 0, 4'b0000);
    add(0, 4'b1111, L(1,1,1,1), 4'b0100, 0, 1, 4'b0000);
    add(0, 4'b1111, L(1,1,1,1), 4'b0000, 0, 1, 4'b0100);
    add(0, 4'b1111, L(1,1,1,1), 4'b0000, 0, 0, 4'b0000);
    add(0, 4'b1111, L(1,1,1,1), 4'b1000, 0, 1, 4'b0000);
    add(0, 4'b1111, L(1,1,1,1), 4'b0000, 0, 1, 4'b1000);
    add(0, 4'b1111, L(1,1,1,1), 4'b0000, 0, 0, 4'b0000);
    add(0, 4'b1111, L(1,1,1,1), 4'b0001, 0, 1, 4'b0000);
    add(0, 4'b0000, L(1,1,1,1), 4'b0000, 0, 1, 4'b0001);
    add(0, 4'b0000, L(1,1,1,1), 4'b0000, 0, 0, 4'b0000);
`endif
    // clr abort at cnt 3, regrant, then req drop and len change are ignored
    add(0, 4'b0001, L(8,0,0,0), 4'b0001, 0, 1, 4'b0000);
    add(0, 4'b0001, L(8,0,0,0), 4'b0001, 1, 1, 4'b0000);
    add(0, 4'b0001, L(8,0,0,0), 4'b0001, 2, 1, 4'b0000);
    add(0, 4'b0001, L(8,0,0,0), 4'b0001, 3, 1, 4'b0000);
    add(1, 4'b0001, L(8,0,0,0), 4'b0000, 0, 0, 4'b0000);
    add(0, 4'b0001, L(8,0,0,0), 4'b0001, 0, 1, 4'b0000);
    for (int c = 1; c <= 7; c++)
      add(0, 4'b0000, L(2,0,0,0), 4'b0001, 8'(c), 1, 4'b0000);
    add(0, 4'b0000, L(2,0,0,0), 4'b0000, 7, 1, 4'b0001);
    add(0, 4'b0000, L(2,0,0,0), 4'b0000, 0, 0, 4'b0000);

    foreach (vecs[i]) begin
      bus.clr = vecs[i].clr;
      bus.req = vecs[i].req;
      bus.len = vecs[i].len;
      @(posedge clk); #1;
      chk($sformatf("v%0d_gnt", i),  32'(bus.gnt),  32'(vecs[i].gnt));
      chk($sformatf("v%0d_cnt", i),  32'(bus.cnt),  32'(vecs[i].cnt));
      chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(vecs[i].busy));
      chk($sformatf("v%0d_done", i), 32'(bus.done), 32'(vecs[i].done));
    end
    bus.clr = 1'b0;

    // len 255: 255 grant cycles, cnt peaks at 254 without wrapping
    bus.req = 4'b0010;
    bus.len = L(0, 255, 0, 0);
    @(posedge clk); #1;
    bus.req = '0;
    n = 0;
    last_cnt = '0;
    while (bus.gnt[1] && n < 300) begin
      n++;
      last_cnt = bus.cnt;
      @(posedge clk); #1;
    end
    chk("max_len_cycles", 32'(n), 255);
    chk("max_len_lastcnt", 32'(last_cnt), 254);
    chk("max_len_done", 32'(bus.done), 32'(4'b0010));
    chk("max_len_donecnt", 32'(bus.cnt), 254);
    @(posedge clk); #1;
    chk("max_len_idle_cnt", 32'(bus.cnt), 0);

    // asynchronous reset mid-slot at cnt 4
    bus.req = 4'b0010;
    bus.len = L(0, 10, 0, 0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk); #1;
      bus.req = '0;
      if (bus.cnt == 8'd4 && bus.gnt == 4'b0010) found = 1'b1;
    end
    chk("arst_reach_cnt4", 32'(found), 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_gnt",  32'(bus.gnt),  0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_cnt",  32'(bus.cnt),  0);
    chk("arst_done", 32'(bus.done), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    done_seen = '0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      done_seen = done_seen | bus.done;
    end
    chk("arst_no_done", 32'(done_seen), 0);
    chk("arst_idle_busy", 32'(bus.busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
